// File: rtl/fan_mode_if.sv
// Button-pulse inputs and fan status outputs of fan_mode_controller.
// The master drives the buttons; the slave (the controller) drives mode, PWM and timer status.
interface fan_mode_if;
  logic        i_btn_speed;
  logic        i_btn_off;
  logic        i_btn_timer;
  logic [1:0]  o_mode;
  logic        o_pwm;
  logic [1:0]  o_timer_sel;
  logic [13:0] o_timer_left_s;

  modport master (
    output i_btn_speed, i_btn_off, i_btn_timer,
    input  o_mode, o_pwm, o_timer_sel, o_timer_left_s
  );

  modport slave (
    input  i_btn_speed, i_btn_off, i_btn_timer,
    output o_mode, o_pwm, o_timer_sel, o_timer_left_s
  );
endinterface

// File: rtl/fan_mode_controller.sv
// Fan speed FSM (OFF/LOW/MID/HIGH) with a period-aligned, glitch-free PWM duty update.
// Define FAN_TIMER_EN to build the auto-off timer; otherwise the timer outputs are tied to zero.
module fan_mode_controller #(
  parameter int unsigned PWM_PERIOD   = 4000,
  parameter int unsigned DUTY_LOW     = 30,
  parameter int unsigned DUTY_MID     = 60,
  parameter int unsigned DUTY_HIGH    = 90,
  parameter int unsigned SEC_CYCLES   = 100_000_000,
  parameter int unsigned TIMER_STEP_S = 3600
) (
  input  logic      i_clk,
  input  logic      i_reset_n,
  fan_mode_if.slave bus
);

  // Counter and duty share one width so a 100 % duty (== PWM_PERIOD) is representable.
  localparam int unsigned W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD + 1) : 1;
  localparam logic [W-1:0] PERIOD_LAST   = W'(PWM_PERIOD - 1);
  localparam logic [W-1:0] DUTY_CNT_LOW  = W'(PWM_PERIOD * DUTY_LOW / 100);
  localparam logic [W-1:0] DUTY_CNT_MID  = W'(PWM_PERIOD * DUTY_MID / 100);
  localparam logic [W-1:0] DUTY_CNT_HIGH = W'(PWM_PERIOD * DUTY_HIGH / 100);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_LOW  = 2'd1,
    MODE_MID  = 2'd2,
    MODE_HIGH = 2'd3
  } mode_e;

  function automatic logic [W-1:0] duty_of(input mode_e m);
    case (m)
      MODE_LOW:  duty_of = DUTY_CNT_LOW;
      MODE_MID:  duty_of = DUTY_CNT_MID;
      MODE_HIGH: duty_of = DUTY_CNT_HIGH;
      default:   duty_of = {W{1'b0}};
    endcase
  endfunction

  mode_e        mode_q, mode_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] duty_q, duty_d;
  logic         pwm_q, pwm_d;
  logic         speed_prev_q, speed_prev_d;
  logic         off_prev_q, off_prev_d;
  logic         speed_rise_s, off_rise_s;

  assign speed_rise_s = bus.i_btn_speed & ~speed_prev_q;
  assign off_rise_s   = bus.i_btn_off & ~off_prev_q;

`ifdef FAN_TIMER_EN
  localparam int unsigned PRE_W = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SEC_CYCLES - 1);

  logic [1:0]       sel_q, sel_d;
  logic [13:0]      left_q, left_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             timer_prev_q, timer_prev_d;
  logic             timer_rise_s;

  assign timer_rise_s       = bus.i_btn_timer & ~timer_prev_q;
  assign bus.o_timer_sel    = sel_q;
  assign bus.o_timer_left_s = left_q;
`else
  logic unused_timer_btn_s;

  assign unused_timer_btn_s = bus.i_btn_timer;
  assign bus.o_timer_sel    = 2'd0;
  assign bus.o_timer_left_s = 14'd0;
`endif

  assign bus.o_mode = mode_q;
  assign bus.o_pwm  = pwm_q;

  // Next-state: button edges, mode FSM, optional off-timer, then PWM counter/duty.
  always_comb begin
    speed_prev_d = bus.i_btn_speed;
    off_prev_d   = bus.i_btn_off;
    mode_d       = mode_q;

    if (off_rise_s) begin
      mode_d = MODE_OFF;
    end else if (speed_rise_s) begin
      case (mode_q)
        MODE_OFF:  mode_d = MODE_LOW;
        MODE_LOW:  mode_d = MODE_MID;
        MODE_MID:  mode_d = MODE_HIGH;
        MODE_HIGH: mode_d = MODE_LOW;
        default:   mode_d = MODE_LOW;
      endcase
    end else begin
      mode_d = mode_q;
    end

`ifdef FAN_TIMER_EN
    timer_prev_d = bus.i_btn_timer;
    sel_d        = sel_q;
    left_d       = left_q;
    pre_d        = pre_q;
    if (off_rise_s) begin
      sel_d  = 2'd0;
      left_d = 14'd0;
      pre_d  = {PRE_W{1'b0}};
    end else if (timer_rise_s && (mode_q != MODE_OFF)) begin
      sel_d  = sel_q + 2'd1;
      left_d = 14'(int'(sel_d) * TIMER_STEP_S);
      pre_d  = {PRE_W{1'b0}};
    end else if (left_q != 14'd0) begin
      if (pre_q == PRE_LAST) begin
        pre_d  = {PRE_W{1'b0}};
        left_d = left_q - 14'd1;
        // Expiry wins over a same-cycle speed press.
        if (left_q == 14'd1) begin
          mode_d = MODE_OFF;
          sel_d  = 2'd0;
        end else begin
          sel_d  = sel_q;
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end else begin
      pre_d = {PRE_W{1'b0}};
    end
`endif

    cnt_d = (cnt_q == PERIOD_LAST) ? {W{1'b0}} : cnt_q + W'(1);

    // Entering OFF stops the motor at once; any other change waits for the period boundary.
    if (mode_d == MODE_OFF) begin
      duty_d = {W{1'b0}};
      pwm_d  = 1'b0;
    end else begin
      pwm_d = (cnt_q < duty_q);
      if (cnt_q == PERIOD_LAST) begin
        duty_d = duty_of(mode_d);
      end else begin
        duty_d = duty_q;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mode_q       <= MODE_OFF;
      cnt_q        <= {W{1'b0}};
      duty_q       <= {W{1'b0}};
      pwm_q        <= 1'b0;
      speed_prev_q <= 1'b0;
      off_prev_q   <= 1'b0;
`ifdef FAN_TIMER_EN
      sel_q        <= 2'd0;
      left_q       <= 14'd0;
      pre_q        <= {PRE_W{1'b0}};
      timer_prev_q <= 1'b0;
`endif
    end else begin
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      duty_q       <= duty_d;
      pwm_q        <= pwm_d;
      speed_prev_q <= speed_prev_d;
      off_prev_q   <= off_prev_d;
`ifdef FAN_TIMER_EN
      sel_q        <= sel_d;
      left_q       <= left_d;
      pre_q        <= pre_d;
      timer_prev_q <= timer_prev_d;
`endif
    end
  end

endmodule

// File: tb/tb_fan_mode_controller.sv
// Self-checking bench for fan_mode_controller: mode table, PWM duty windows, timer countdown
// (when FAN_TIMER_EN is defined), async reset, and randomized buttons against a reference model.
module tb_fan_mode_controller;
  localparam int P    = 100;
  localparam int SEC  = 10;
  localparam int STEP = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  fan_mode_if bus();

  fan_mode_controller #(
    .PWM_PERIOD(P), .DUTY_LOW(30), .DUTY_MID(60), .DUTY_HIGH(90),
    .SEC_CYCLES(SEC), .TIMER_STEP_S(STEP)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: fan speed as an index into a percent table, PWM as position within a period.
  int m_mode, m_pos, m_high, m_pwm, m_sel, m_left, m_ticks;
  bit m_prev_s, m_prev_o, m_prev_t;

  function automatic int high_cycles(input int mode);
    int pct;
    case (mode)
      1:       pct = 30;
      2:       pct = 60;
      3:       pct = 90;
      default: pct = 0;
    endcase
    return P * pct / 100;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_high = 0; m_pwm = 0;
    m_sel = 0; m_left = 0; m_ticks = 0;
    m_prev_s = 0; m_prev_o = 0; m_prev_t = 0;
  endtask

  task automatic model_step(input bit s, input bit o, input bit t);
    bit press_s, press_o, press_t;
    int nm;
    press_s = s && !m_prev_s;
    press_o = o && !m_prev_o;
    press_t = t && !m_prev_t;
    m_prev_s = s; m_prev_o = o; m_prev_t = t;
    nm = m_mode;
    if (press_o) nm = 0;
    else if (press_s) nm = (m_mode == 3) ? 1 : m_mode + 1;
`ifdef FAN_TIMER_EN
    if (press_o) begin
      m_sel = 0; m_left = 0; m_ticks = 0;
    end else if (press_t && m_mode != 0) begin
      m_sel = (m_sel + 1) % 4;
      m_left = m_sel * STEP;
      m_ticks = 0;
    end else if (m_left > 0) begin
      m_ticks++;
      if (m_ticks == SEC) begin
        m_ticks = 0;
        m_left--;
        if (m_left == 0) begin nm = 0; m_sel = 0; end
      end
    end
`else
    if (press_t) m_sel = 0;
`endif
    if (nm == 0) begin
      m_pwm = 0; m_high = 0;
    end else begin
      m_pwm = (m_pos < m_high) ? 1 : 0;
      if (m_pos == P - 1) m_high = high_cycles(nm);
    end
    m_mode = nm;
    m_pos = (m_pos + 1) % P;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("mode", int'(bus.o_mode), m_mode);
    check("pwm", int'(bus.o_pwm), m_pwm);
    check("timer_sel", int'(bus.o_timer_sel), m_sel);
    check("timer_left", int'(bus.o_timer_left_s), m_left);
  endtask

  // One clock: drive at the negedge, step the model at the posedge, compare at the next negedge.
  task automatic tick(input bit s, input bit o, input bit t);
    bus.i_btn_speed = s; bus.i_btn_off = o; bus.i_btn_timer = t;
    @(posedge clk);
    model_step(s, o, t);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic align(input int target);
    int guard = 0;
    while (m_pos != target && guard < 2 * P) begin
      tick(1'b0, 1'b0, 1'b0);
      guard++;
    end
    check("align_reached", m_pos, target);
  endtask

  typedef struct {
    bit s;
    bit o;
    bit t;
    int exp_mode;
  } vec_t;

  vec_t tbl[9];
  int   highs;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 2};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 3};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 2};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1};

    bus.i_btn_speed = 1'b0; bus.i_btn_off = 1'b0; bus.i_btn_timer = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Idle after reset: fan stays off.
    highs = 0;
    for (int i = 0; i < 500; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      highs += int'(bus.o_pwm);
    end
    check("idle_pwm_highs", highs, 0);

    // Mode sequence, each press followed by a release cycle.
    for (int i = 0; i < 9; i++) begin
      tick(tbl[i].s, tbl[i].o, tbl[i].t);
      check("table_mode", int'(bus.o_mode), tbl[i].exp_mode);
      tick(1'b0, 1'b0, 1'b0);
    end

    // LOW: 30 highs per period window.
    align(0);
    highs = 0;
    for (int i = 0; i < P; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      highs += int'(bus.o_pwm);
    end
    check("low_window_highs", highs, 30);

    // Speed press at counter 50: this window keeps 30, the next has 60.
    highs = 0;
    for (int i = 0; i < P; i++) begin
      tick(i == 50, 1'b0, 1'b0);
      highs += int'(bus.o_pwm);
    end
    check("midchange_old_window", highs, 30);
    highs = 0;
    for (int i = 0; i < P; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      highs += int'(bus.o_pwm);
    end
    check("midchange_new_window", highs, 60);

    // HIGH, then speed+off together while the PWM is high.
    tick(1'b1, 1'b0, 1'b0);
    idle(2 * P);
    align(10);
    check("pwm_high_before_off", int'(bus.o_pwm), 1);
    tick(1'b1, 1'b1, 1'b0);
    check("speed_off_mode", int'(bus.o_mode), 0);
    check("speed_off_pwm", int'(bus.o_pwm), 0);
    tick(1'b0, 1'b0, 1'b0);
    highs = 0;
    for (int i = 0; i < 2 * P; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      highs += int'(bus.o_pwm);
    end
    check("off_pwm_highs", highs, 0);

`ifdef FAN_TIMER_EN
    // Timer while OFF is ignored.
    tick(1'b0, 1'b0, 1'b1);
    check("timer_off_ignored", int'(bus.o_timer_sel), 0);
    tick(1'b0, 1'b0, 1'b0);
    // LOW, one timer press, then countdown to auto-off.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check("timer_sel_load", int'(bus.o_timer_sel), 1);
    check("timer_left_load", int'(bus.o_timer_left_s), 5);
    for (int s = 5; s >= 1; s--) begin
      for (int k = 0; k < SEC - 1; k++) tick(1'b0, 1'b0, 1'b0);
      check("timer_hold", int'(bus.o_timer_left_s), s);
      tick(1'b0, 1'b0, 1'b0);
      check("timer_step", int'(bus.o_timer_left_s), s - 1);
      check("timer_mode", int'(bus.o_mode), (s == 1) ? 0 : 1);
    end
    check("timer_sel_expired", int'(bus.o_timer_sel), 0);
`endif

    // Held speed button advances once.
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0);
    check("held_speed_mode", int'(bus.o_mode), 1);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    idle(2 * P);
    align(20);
    check("pwm_high_before_reset", int'(bus.o_pwm), 1);

    // Asynchronous reset mid-period, away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(P);

    // Randomized buttons against the model.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
